fp_class_arbiter: RTL and testbench

- Shares one combinational fp_class classifier among NREQ requesters using a round-robin arbiter and a valid/ready handshake on each port.
- Registers the classified result (exponent, significand, type flags) together with the requester ID in a single output stage with backpressure.
- Sits in front of the FPU datapath, e.g. feeding operand classification for fp_add from several operand queues.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_class.sv | 58 +++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/fp_class_arbiter.sv | 109 ++++++++++
 tb/tb_fp_class_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point classification constants: class flag indices and
// exponent bias helpers, parameterised on the exponent/significand widths.
package fp_pkg;

  localparam int NTYPES = 6;

  localparam int SNAN      = 0;
  localparam int QNAN      = 1;
  localparam int INFINITY  = 2;
  localparam int ZERO      = 3;
  localparam int SUBNORMAL = 4;
  localparam int NORMAL    = 5;

  function automatic int fp_bias(input int nexp);
    return (1 << (nexp - 1)) - 1;
  endfunction

  // The significand width does not move the bias; it is kept in the
  // signature so both derivations take the same format description.
  function automatic int fp_emin(input int nexp, input int nsig);
    return 1 - fp_bias(nexp) + (nsig - nsig);
  endfunction

endpackage

// File: rtl/fp_class.sv
// Combinational classifier: splits an IEEE-style operand into unbiased
// exponent, significand with explicit leading one, and a one-hot class.
module fp_class
  import fp_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input  logic [NEXP+NSIG:0]      f,
  output logic signed [NEXP+1:0]  fexp,
  output logic [NSIG:0]           fsig,
  output logic [NTYPES-1:0]       flags
);

  localparam int SW = $clog2(NSIG + 1);
  localparam logic signed [NEXP+1:0] BIAS_V = (NEXP+2)'(fp_bias(NEXP));
  localparam logic signed [NEXP+1:0] EMIN_V = (NEXP+2)'(fp_emin(NEXP, NSIG));

  logic [NEXP-1:0] e;
  logic [NSIG-1:0] frac;
  logic [SW-1:0]   shift;

  assign e    = f[NEXP+NSIG-1:NSIG];
  assign frac = f[NSIG-1:0];

  // NOTE: every output of an always_comb gets a default up front so that no
  // path through the case logic leaves it unassigned and infers a latch.
  always_comb begin
    flags = '0;
    fexp  = $signed({2'b00, e});
    fsig  = {1'b0, frac};
    shift = '0;
    // Ascending scan: the last hit is the highest set bit, i.e. the smallest
    // shift that moves the leading one into the implied-one position.
    for (int i = 0; i < NSIG; i++) begin
      if (frac[i]) shift = SW'(NSIG - i);
    end

    if (&e) begin
      if (frac == '0)          flags[INFINITY] = 1'b1;
      else if (frac[NSIG-1])   flags[QNAN]     = 1'b1;
      else                     flags[SNAN]     = 1'b1;
    end else if (e == '0) begin
      if (frac == '0) begin
        flags[ZERO] = 1'b1;
      end else begin
        flags[SUBNORMAL] = 1'b1;
        fexp = EMIN_V - $signed((NEXP+2)'(shift));
        fsig = {1'b0, frac} << shift;
      end
    end else begin
      flags[NORMAL] = 1'b1;
      fexp = $signed({2'b00, e}) - BIAS_V;
      fsig = {1'b1, frac};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches upward from ptr with wraparound; the first
// requesting index wins. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    // The index is reported even when disabled so the data mux can settle
    // early; only the grant vector is gated.
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/fp_class_arbiter.sv
// Shares one fp_class among NREQ valid/ready requesters via round-robin
// arbitration and registers the result with its requester ID.
module fp_class_arbiter
  import fp_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*(NEXP+NSIG+1)-1:0] req_f,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [NEXP+1:0]     out_exp,
  output logic [NSIG:0]              out_sig,
  output logic [NTYPES-1:0]          out_flags,
  output logic [IDW-1:0]             out_id
);

  localparam int W = NEXP + NSIG + 1;

  logic                      out_valid_q, out_valid_d;
  logic signed [NEXP+1:0]    out_exp_q,   out_exp_d;
  logic [NSIG:0]             out_sig_q,   out_sig_d;
  logic [NTYPES-1:0]         out_flags_q, out_flags_d;
  logic [IDW-1:0]            out_id_q,    out_id_d;
  logic [IDW-1:0]            ptr_q,       ptr_d;

  logic                      can_load;
  logic [NREQ-1:0]           gnt;
  logic [IDW-1:0]            gnt_idx;
  logic                      xfer;
  logic [W-1:0]              sel_f;
  logic signed [NEXP+1:0]    cls_exp;
  logic [NSIG:0]             cls_sig;
  logic [NTYPES-1:0]         cls_flags;

  assign can_load = ~out_valid_q | out_ready;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (can_load & ~rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_f     = req_f[int'(gnt_idx)*W +: W];

  fp_class #(.NEXP(NEXP), .NSIG(NSIG)) u_class (
    .f     (sel_f),
    .fexp  (cls_exp),
    .fsig  (cls_sig),
    .flags (cls_flags)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_exp_d   = out_exp_q;
    out_sig_d   = out_sig_q;
    out_flags_d = out_flags_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_exp_d   = cls_exp;
      out_sig_d   = cls_sig;
      out_flags_d = cls_flags;
      out_id_d    = gnt_idx;
      ptr_d       = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      // Drain without reload: data fields keep their last value.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
      out_flags_q <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_exp_q   <= out_exp_d;
      out_sig_q   <= out_sig_d;
      out_flags_q <= out_flags_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;
  assign out_flags = out_flags_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_fp_class_arbiter.sv
// Directed bench for fp_class_arbiter: classification results, round-robin
// order, backpressure, fairness and mid-operation reset.
module tb_fp_class_arbiter;
  import fp_pkg::*;

  localparam int NEXP = 5;
  localparam int NSIG = 10;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = NEXP + NSIG + 1;

  localparam logic [NTYPES-1:0] F_SNAN = NTYPES'(1 << SNAN);
  localparam logic [NTYPES-1:0] F_QNAN = NTYPES'(1 << QNAN);
  localparam logic [NTYPES-1:0] F_INF  = NTYPES'(1 << INFINITY);
  localparam logic [NTYPES-1:0] F_ZERO = NTYPES'(1 << ZERO);
  localparam logic [NTYPES-1:0] F_SUB  = NTYPES'(1 << SUBNORMAL);
  localparam logic [NTYPES-1:0] F_NORM = NTYPES'(1 << NORMAL);

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_f;
  logic                 out_valid;
  logic                 out_ready;
  logic [NEXP+1:0]      out_exp;
  logic [NSIG:0]        out_sig;
  logic [NTYPES-1:0]    out_flags;
  logic [IDW-1:0]       out_id;

  int n_checks;
  int n_errors;

  fp_class_arbiter #(.NEXP(NEXP), .NSIG(NSIG), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_f     (req_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .out_sig   (out_sig),
    .out_flags (out_flags),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input int k, input logic [W-1:0] v);
    req_f[k*W +: W] = v;
  endtask

  logic [NTYPES-1:0] strm_flags [NREQ];
  int                seq3 [4];

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    req_valid = 4'hF;
    out_ready = 1'b1;
    req_f     = '0;
    n_checks  = 0;
    n_errors  = 0;
    strm_flags = '{F_SUB, F_INF, F_ZERO, F_QNAN};
    seq3       = '{3, 2, 3, 2};

    // Reset state; requesters valid but nothing may be accepted during rst.
    tick();
    check("rst_ready",   32'(req_ready), 32'h0);
    check("rst_valid",   32'(out_valid), 32'h0);
    check("rst_exp",     32'(out_exp),   32'h0);
    check("rst_sig",     32'(out_sig),   32'h0);
    check("rst_flags",   32'(out_flags), 32'h0);
    check("rst_id",      32'(out_id),    32'h0);

    // Single requester, 1.0
    rst       = 1'b0;
    req_valid = 4'b0001;
    set_f(0, 16'h3C00);
    #1;
    check("one_ready",   32'(req_ready), 32'h1);
    tick();
    check("one_valid",   32'(out_valid), 32'h1);
    check("one_exp",     32'(out_exp),   32'h0);
    check("one_sig",     32'(out_sig),   32'h400);
    check("one_flags",   32'(out_flags), 32'(F_NORM));
    check("one_id",      32'(out_id),    32'h0);
    req_valid = 4'b0000;
    tick();
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_hold",  32'(out_sig),   32'h400);

    // Fresh pointer, then all four requesters streaming for two rotations.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_f(0, 16'h0001);
    set_f(1, 16'h7C00);
    set_f(2, 16'h0000);
    set_f(3, 16'h7E00);
    req_valid = 4'hF;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NREQ; k++) begin
        #1;
        check($sformatf("strm_ready_%0d_%0d", r, k), 32'(req_ready), 32'(1 << k));
        tick();
        check($sformatf("strm_id_%0d_%0d", r, k),    32'(out_id),    32'(k));
        check($sformatf("strm_flags_%0d_%0d", r, k), 32'(out_flags), 32'(strm_flags[k]));
        if (k == 0) begin
          check($sformatf("strm_exp_%0d", r), 32'(out_exp), 32'h68);
          check($sformatf("strm_sig_%0d", r), 32'(out_sig), 32'h400);
        end
      end
    end

    // Backpressure: output frozen on the id 3 result, no requester accepted.
    out_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(req_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'h1);
      check($sformatf("bp_id_%0d", c),    32'(out_id),    32'h3);
      check($sformatf("bp_flags_%0d", c), 32'(out_flags), 32'(F_QNAN));
      check($sformatf("bp_ready_%0d", c), 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(req_ready), 32'h1);
    tick();
    check("bp_rel_id",    32'(out_id),    32'h0);
    check("bp_rel_flags", 32'(out_flags), 32'(F_SUB));

    // Move the pointer to 3 via a lone grant to requester 2.
    req_valid = 4'b0100;
    #1;
    check("pre_ready", 32'(req_ready), 32'h4);
    tick();
    check("pre_id",    32'(out_id),    32'h2);

    // Fairness between requesters 2 and 3 starting at pointer 3.
    req_valid = 4'b1100;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("fair_ready_%0d", c), 32'(req_ready), 32'(1 << seq3[c]));
      tick();
      check($sformatf("fair_id_%0d", c),    32'(out_id),    32'(seq3[c]));
    end

    // Sign and NaN edge cases; pointer is 3, so requester 0 goes first.
    set_f(0, 16'h7C01);
    set_f(1, 16'h8400);
    req_valid = 4'b0011;
    #1;
    check("snan_ready", 32'(req_ready), 32'h1);
    tick();
    check("snan_id",    32'(out_id),    32'h0);
    check("snan_flags", 32'(out_flags), 32'(F_SNAN));
    #1;
    check("neg_ready",  32'(req_ready), 32'h2);
    tick();
    check("neg_id",     32'(out_id),    32'h1);
    check("neg_flags",  32'(out_flags), 32'(F_NORM));
    check("neg_exp",    32'(out_exp),   32'h72);
    check("neg_sig",    32'(out_sig),   32'h400);

    // Reset during a stall; pointer (now 2) must return to 0.
    out_ready = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("mid_stall_ready", 32'(req_ready), 32'h0);
    check("mid_stall_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid",   32'(out_valid), 32'h0);
    check("mid_rst_ready",   32'(req_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("mid_post_ready",  32'(req_ready), 32'h2);
    tick();
    check("mid_post_valid",  32'(out_valid), 32'h1);
    check("mid_post_id",     32'(out_id),    32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
